// File: rtl/bram_write_pkg.sv
// Shared constants for the BRAM write streamer: FSM encoding and parameter defaults.
package bram_write_pkg;

  localparam int unsigned DEF_DATA_WIDTH              = 8;
  localparam int unsigned DEF_LOG_MAX_ITERS           = 16;
  localparam int unsigned DEF_LOG_MAX_WRITES_PER_ITER = 16;
  localparam int unsigned DEF_LOG_MAX_ADDRESS         = 16;

  localparam int unsigned FIFO_SLOTS       = 4;
  localparam int unsigned FIFO_LOG_SLOTS   = 2;
  localparam int unsigned FIFO_ALMOST_FULL = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bram_write_if.sv
// Configuration, stream and BRAM-side signals of the BRAM write streamer.
interface bram_write_if
  import bram_write_pkg::*;
#(
  parameter int unsigned DATA_WIDTH              = DEF_DATA_WIDTH,
  parameter int unsigned LOG_MAX_ITERS           = DEF_LOG_MAX_ITERS,
  parameter int unsigned LOG_MAX_WRITES_PER_ITER = DEF_LOG_MAX_WRITES_PER_ITER,
  parameter int unsigned LOG_MAX_ADDRESS         = DEF_LOG_MAX_ADDRESS
);

  logic                               configure;
  logic [LOG_MAX_ITERS-1:0]           num_iters;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter;
  logic [LOG_MAX_ADDRESS-1:0]         base_address;
  logic                               valid_in;
  logic [DATA_WIDTH-1:0]              data_in;
  logic                               avail_out;
  logic [LOG_MAX_ADDRESS-1:0]         address_out;
  logic [DATA_WIDTH-1:0]              data_out;
  logic                               write_out;
  logic                               done_out;
  logic                               overflow_out;

  modport master (
    output configure, num_iters, num_writes_per_iter, base_address, valid_in, data_in,
    input  avail_out, address_out, data_out, write_out, done_out, overflow_out
  );

  modport slave (
    input  configure, num_iters, num_writes_per_iter, base_address, valid_in, data_in,
    output avail_out, address_out, data_out, write_out, done_out, overflow_out
  );

endinterface

// File: rtl/bram_write_fifo.sv
// Small synchronous FIFO with flush; NUM_SLOTS must be a power of two.
module bram_write_fifo #(
  parameter int unsigned NUM_SLOTS     = 4,
  parameter int unsigned LOG_NUM_SLOTS = 2,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    head,
  output logic                     empty,
  output logic                     full,
  output logic [LOG_NUM_SLOTS:0]   count
);

  localparam logic [LOG_NUM_SLOTS:0]   FULL_COUNT = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0]   CNT_ONE    = (LOG_NUM_SLOTS+1)'(1);
  localparam logic [LOG_NUM_SLOTS-1:0] PTR_ONE    = LOG_NUM_SLOTS'(1);

  logic [DATA_WIDTH-1:0]    mem [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] rd_ptr;
  logic [LOG_NUM_SLOTS-1:0] wr_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are only observed while non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush discards everything in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_write.sv
// Streams FIFO-buffered words into BRAM over num_iters passes of num_writes_per_iter
// consecutive addresses starting at base_address.
module bram_write
  import bram_write_pkg::*;
#(
  parameter int unsigned DATA_WIDTH              = DEF_DATA_WIDTH,
  parameter int unsigned LOG_MAX_ITERS           = DEF_LOG_MAX_ITERS,
  parameter int unsigned LOG_MAX_WRITES_PER_ITER = DEF_LOG_MAX_WRITES_PER_ITER,
  parameter int unsigned LOG_MAX_ADDRESS         = DEF_LOG_MAX_ADDRESS
) (
  input  logic         clk,
  input  logic         rst,
  bram_write_if.slave  bus
);

  localparam int unsigned CNT_W = FIFO_LOG_SLOTS + 1;
  localparam logic [LOG_MAX_ITERS-1:0]           I_ONE = LOG_MAX_ITERS'(1);
  localparam logic [LOG_MAX_WRITES_PER_ITER-1:0] W_ONE = LOG_MAX_WRITES_PER_ITER'(1);
  localparam logic [LOG_MAX_ADDRESS-1:0]         A_ONE = LOG_MAX_ADDRESS'(1);
  localparam logic [CNT_W-1:0]                   ALMOST_FULL = CNT_W'(FIFO_ALMOST_FULL);

  logic [1:0]                         state;
  logic [1:0]                         state_nxt;
  logic [LOG_MAX_ITERS-1:0]           iters_left;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_left;
  logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_cfg;
  logic [LOG_MAX_ADDRESS-1:0]         addr;
  logic [LOG_MAX_ADDRESS-1:0]         base_cfg;
  logic [DATA_WIDTH-1:0]              data_hold;
  logic [DATA_WIDTH-1:0]              fifo_head;
  logic                               fifo_empty;
  logic                               fifo_full;
  logic [CNT_W-1:0]                   fifo_count;
  logic                               overflow;
  logic                               running;
  logic                               write;
  logic                               last_write;
  logic                               counts_ok;

  assign running    = (state == ST_RUN);
  assign write      = running && !fifo_empty && !bus.configure;
  assign last_write = write && (writes_left == W_ONE) && (iters_left == I_ONE);
  assign counts_ok  = (bus.num_iters != '0) && (bus.num_writes_per_iter != '0);

  bram_write_fifo #(
    .NUM_SLOTS     (FIFO_SLOTS),
    .LOG_NUM_SLOTS (FIFO_LOG_SLOTS),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.configure),
    .push      (bus.valid_in),
    .push_data (bus.data_in),
    .pop       (write),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state; configure overrides whatever the FSM is doing.
  always_comb begin
    state_nxt = state;
    if (bus.configure) begin
      state_nxt = counts_ok ? ST_RUN : ST_DONE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_RUN:  if (last_write) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Iteration/write counters and the running address, reloaded at each pass boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iters_left  <= '0;
      writes_left <= '0;
      writes_cfg  <= '0;
      addr        <= '0;
      base_cfg    <= '0;
    end else if (bus.configure) begin
      iters_left  <= bus.num_iters;
      writes_left <= bus.num_writes_per_iter;
      writes_cfg  <= bus.num_writes_per_iter;
      addr        <= bus.base_address;
      base_cfg    <= bus.base_address;
    end else if (write) begin
      if (writes_left != W_ONE) begin
        writes_left <= writes_left - W_ONE;
        addr        <= addr + A_ONE;
      end else if (iters_left != I_ONE) begin
        iters_left  <= iters_left - I_ONE;
        writes_left <= writes_cfg;
        addr        <= base_cfg;
      end
    end
  end

  // Sticky drop flag, cleared only by configure or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                overflow <= 1'b0;
    else if (bus.configure)                 overflow <= 1'b0;
    else if (bus.valid_in && fifo_full)     overflow <= 1'b1;
  end

  // Last written word, so data_out holds steady between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        data_hold <= '0;
    else if (write) data_hold <= fifo_head;
  end

  assign bus.avail_out    = running && (fifo_count < ALMOST_FULL);
  assign bus.write_out    = write;
  assign bus.address_out  = addr;
  assign bus.data_out     = write ? fifo_head : data_hold;
  assign bus.done_out     = (state == ST_DONE);
  assign bus.overflow_out = overflow;

endmodule

// File: tb/tb_bram_write.sv
// Self-checking bench: two DUTs (16-bit and 4-bit address) share one stimulus
// and are compared every cycle against a queue-based model, plus literal checks.
module tb_bram_write;

  localparam int unsigned DW   = 8;
  localparam int unsigned LI   = 16;
  localparam int unsigned LW   = 16;
  localparam int unsigned LA   = 16;
  localparam int unsigned LA_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          configure;
  logic [LI-1:0] num_iters;
  logic [LW-1:0] num_writes;
  logic [LA-1:0] base;
  logic          valid_in;
  logic [DW-1:0] data_in;

  bram_write_if #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_WRITES_PER_ITER(LW),
                  .LOG_MAX_ADDRESS(LA)) bus_a ();
  bram_write_if #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_WRITES_PER_ITER(LW),
                  .LOG_MAX_ADDRESS(LA_W)) bus_b ();

  bram_write #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_WRITES_PER_ITER(LW),
               .LOG_MAX_ADDRESS(LA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  bram_write #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_WRITES_PER_ITER(LW),
               .LOG_MAX_ADDRESS(LA_W)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_a.configure           = configure;
  assign bus_a.num_iters           = num_iters;
  assign bus_a.num_writes_per_iter = num_writes;
  assign bus_a.base_address        = base;
  assign bus_a.valid_in            = valid_in;
  assign bus_a.data_in             = data_in;
  assign bus_b.configure           = configure;
  assign bus_b.num_iters           = num_iters;
  assign bus_b.num_writes_per_iter = num_writes;
  assign bus_b.base_address        = base[LA_W-1:0];
  assign bus_b.valid_in            = valid_in;
  assign bus_b.data_in             = data_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: words accepted so far, job totals, and a write index k; the k-th write
  // of a job goes to base + (k mod writes_per_iter).
  logic [DW-1:0] mq[$];
  bit            m_run, m_done, m_ovf;
  longint        m_total, m_k;
  longint        m_w;
  logic [LA-1:0] m_base;
  logic [DW-1:0] m_last;

  int            cyc_n = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            last_wr_cyc = 0;
  logic [LA-1:0]   cap_a[$];
  logic [LA_W-1:0] cap_b[$];
  logic [DW-1:0]   cap_d[$];

  // Per-cycle compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    bit              ew;
    bit              was_full;
    logic [LA-1:0]   ea;
    logic [LA_W-1:0] eb;
    cyc_n++;
    if (rst) begin
      chk("rst_avail_a", 64'(bus_a.avail_out), 64'd0);
      chk("rst_write_a", 64'(bus_a.write_out), 64'd0);
      chk("rst_done_a",  64'(bus_a.done_out), 64'd0);
      chk("rst_ovf_a",   64'(bus_a.overflow_out), 64'd0);
      chk("rst_addr_a",  64'(bus_a.address_out), 64'd0);
      chk("rst_data_a",  64'(bus_a.data_out), 64'd0);
      chk("rst_write_b", 64'(bus_b.write_out), 64'd0);
      chk("rst_addr_b",  64'(bus_b.address_out), 64'd0);
      mq.delete();
      m_run = 0; m_done = 0; m_ovf = 0;
      m_total = 0; m_k = 0; m_w = 0; m_base = '0; m_last = '0;
    end else begin
      ew = m_run && (mq.size() > 0) && !configure;
      ea = '0;
      if (ew) ea = m_base + LA'(m_k % m_w);
      eb = ea[LA_W-1:0];
      chk("write_a", 64'(bus_a.write_out), 64'(ew));
      chk("write_b", 64'(bus_b.write_out), 64'(ew));
      chk("done_a",  64'(bus_a.done_out), 64'(m_done));
      chk("done_b",  64'(bus_b.done_out), 64'(m_done));
      chk("avail_a", 64'(bus_a.avail_out), 64'(m_run && (mq.size() < 3)));
      chk("avail_b", 64'(bus_b.avail_out), 64'(m_run && (mq.size() < 3)));
      chk("ovf_a",   64'(bus_a.overflow_out), 64'(m_ovf));
      chk("ovf_b",   64'(bus_b.overflow_out), 64'(m_ovf));
      if (ew) begin
        chk("addr_a", 64'(bus_a.address_out), 64'(ea));
        chk("addr_b", 64'(bus_b.address_out), 64'(eb));
        chk("data_a", 64'(bus_a.data_out), 64'(mq[0]));
        chk("data_b", 64'(bus_b.data_out), 64'(mq[0]));
      end else begin
        chk("hold_data_a", 64'(bus_a.data_out), 64'(m_last));
        chk("hold_data_b", 64'(bus_b.data_out), 64'(m_last));
      end
      if (bus_a.write_out) begin
        cap_a.push_back(bus_a.address_out);
        cap_d.push_back(bus_a.data_out);
        last_wr_cyc = cyc_n;
      end
      if (bus_b.write_out) cap_b.push_back(bus_b.address_out);
      if (bus_a.done_out) begin
        done_cnt++;
        done_cyc = cyc_n;
      end
      if (configure) begin
        mq.delete();
        m_ovf   = 0;
        m_w     = longint'(num_writes);
        m_base  = base;
        m_total = longint'(num_iters) * longint'(num_writes);
        m_k     = 0;
        m_run   = (m_total != 0);
        m_done  = !m_run;
      end else begin
        was_full = (mq.size() >= 4);
        m_done   = 0;
        if (ew) begin
          m_last = mq.pop_front();
          m_k++;
          if (m_k == m_total) begin
            m_run  = 0;
            m_done = 1;
          end
        end
        if (valid_in) begin
          if (was_full) m_ovf = 1;
          else          mq.push_back(data_in);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    cap_a.delete();
    cap_b.delete();
    cap_d.delete();
    done_cnt = 0;
  endtask

  task automatic do_config(input logic [LI-1:0] ni, input logic [LW-1:0] nw,
                           input logic [LA-1:0] b);
    configure  = 1'b1;
    num_iters  = ni;
    num_writes = nw;
    base       = b;
    cyc();
    configure  = 1'b0;
  endtask

  task automatic stream(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      data_in  = first + DW'(i);
      cyc();
    end
    valid_in = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [LA-1:0] a,
                        input logic [DW-1:0] d);
    if (idx < cap_a.size()) begin
      chk({tag, "_addr"}, 64'(cap_a[idx]), 64'(a));
      chk({tag, "_data"}, 64'(cap_d[idx]), 64'(d));
    end
  endtask

  initial begin
    configure = 1'b0; valid_in = 1'b0; num_iters = '0; num_writes = '0;
    base = '0; data_in = '0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic run: 4 writes to 0x10..0x13.
    clear_log();
    do_config(16'd1, 16'd4, 16'h0010);
    stream(8'hA0, 4);
    idle(6);
    chk("basic_count", 64'(cap_a.size()), 64'd4);
    chk_wr("basic0", 0, 16'h0010, 8'hA0);
    chk_wr("basic1", 1, 16'h0011, 8'hA1);
    chk_wr("basic2", 2, 16'h0012, 8'hA2);
    chk_wr("basic3", 3, 16'h0013, 8'hA3);
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);
    chk("basic_done_cyc", 64'(done_cyc), 64'(last_wr_cyc + 1));

    // Two iterations of 3 writes from 0x20.
    clear_log();
    do_config(16'd2, 16'd3, 16'h0020);
    stream(8'hB0, 6);
    idle(6);
    chk("reload_count", 64'(cap_a.size()), 64'd6);
    chk_wr("reload0", 0, 16'h0020, 8'hB0);
    chk_wr("reload1", 1, 16'h0021, 8'hB1);
    chk_wr("reload2", 2, 16'h0022, 8'hB2);
    chk_wr("reload3", 3, 16'h0020, 8'hB3);
    chk_wr("reload4", 4, 16'h0021, 8'hB4);
    chk_wr("reload5", 5, 16'h0022, 8'hB5);
    chk("reload_done_cnt", 64'(done_cnt), 64'd1);
    chk("reload_done_cyc", 64'(done_cyc), 64'(last_wr_cyc + 1));

    // Backpressure in IDLE: four words fit, the fifth is dropped.
    clear_log();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      data_in  = 8'hC0 + DW'(i);
      mid();
      chk("bp_avail", 64'(bus_a.avail_out), 64'd0);
      chk("bp_ovf_before", 64'(bus_a.overflow_out), 64'd0);
      cyc();
    end
    valid_in = 1'b0;
    mid();
    chk("bp_ovf_after_a", 64'(bus_a.overflow_out), 64'd1);
    chk("bp_ovf_after_b", 64'(bus_b.overflow_out), 64'd1);
    chk("bp_no_writes", 64'(cap_a.size()), 64'd0);
    cyc();

    // Zero write count: done one cycle after configure, overflow cleared, no writes.
    clear_log();
    configure = 1'b1; num_iters = 16'd1; num_writes = 16'd0; base = 16'h0005;
    mid();
    chk("zero_done_cfg_cycle", 64'(bus_a.done_out), 64'd0);
    cyc();
    configure = 1'b0;
    mid();
    chk("zero_done_pulse", 64'(bus_a.done_out), 64'd1);
    chk("zero_ovf_cleared", 64'(bus_a.overflow_out), 64'd0);
    cyc();
    mid();
    chk("zero_done_gone", 64'(bus_a.done_out), 64'd0);
    idle(3);
    chk("zero_no_writes", 64'(cap_a.size()), 64'd0);
    chk("zero_done_cnt", 64'(done_cnt), 64'd1);

    // Address wrap on the 4-bit address instance.
    clear_log();
    do_config(16'd1, 16'd4, 16'h000E);
    stream(8'hD0, 4);
    idle(6);
    chk("wrap_count", 64'(cap_b.size()), 64'd4);
    if (cap_b.size() == 4) begin
      chk("wrap0", 64'(cap_b[0]), 64'hE);
      chk("wrap1", 64'(cap_b[1]), 64'hF);
      chk("wrap2", 64'(cap_b[2]), 64'h0);
      chk("wrap3", 64'(cap_b[3]), 64'h1);
    end
    chk_wr("wide2", 2, 16'h0010, 8'hD2);

    // Reset after two of four writes.
    clear_log();
    do_config(16'd1, 16'd4, 16'h0030);
    stream(8'hE0, 3);
    chk("mid_writes_before_rst", 64'(cap_a.size()), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_write",   64'(bus_a.write_out), 64'd0);
    chk("mid_rst_avail",   64'(bus_a.avail_out), 64'd0);
    chk("mid_rst_done",    64'(bus_a.done_out), 64'd0);
    chk("mid_rst_ovf",     64'(bus_a.overflow_out), 64'd0);
    chk("mid_rst_addr",    64'(bus_a.address_out), 64'd0);
    chk("mid_rst_data",    64'(bus_a.data_out), 64'd0);
    chk("mid_rst_addr_b",  64'(bus_b.address_out), 64'd0);
    idle(2);
    rst = 1'b0;
    stream(8'hF0, 2);
    idle(5);
    chk("mid_no_writes_after", 64'(cap_a.size()), 64'd2);
    chk("mid_no_done", 64'(done_cnt), 64'd0);

    // Fresh configure after reset resumes normally with a flushed FIFO.
    clear_log();
    do_config(16'd1, 16'd2, 16'h0040);
    stream(8'h50, 2);
    idle(5);
    chk("resume_count", 64'(cap_a.size()), 64'd2);
    chk_wr("resume0", 0, 16'h0040, 8'h50);
    chk_wr("resume1", 1, 16'h0041, 8'h51);
    chk("resume_done_cnt", 64'(done_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
